// File: rtl/dcache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_defs (package)
// Brief   : Geometry and FSM state encoding shared by the data cache files.
// Revision: 1.0
// ============================================================================
package cache_defs;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;
    localparam int IDX_W       = $clog2(NUM_BLOCKS);
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W       = BLOCK_BYTES * 8;
    localparam int MADDR_W     = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    function automatic logic [7:0] sel_byte(input logic [BLK_W-1:0] blk,
                                            input logic [OFF_W-1:0] off);
        return blk[off*8 +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_controller_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module  : cache_line_array
// Brief   : Per-line valid/dirty/tag/data storage with byte-write and block-fill.
// Revision: 1.0
// ============================================================================
module cache_line_array
    import cache_defs::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [TAG_W-1:0]     o_tag,
    output logic [BLK_W-1:0]     o_data,
    input  logic                 i_wr_en,
    input  logic [OFF_W-1:0]     i_wr_off,
    input  logic [7:0]           i_wr_byte,
    input  logic                 i_fill_en,
    input  logic [IDX_W-1:0]     i_fill_idx,
    input  logic [TAG_W-1:0]     i_fill_tag,
    input  logic [BLK_W-1:0]     i_fill_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLK_W-1:0]      r_data [NUM_BLOCKS];

    assign o_valid = r_valid[i_rd_idx];
    assign o_dirty = r_dirty[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];
    assign o_data  = r_data[i_rd_idx];

    // Only the status bits are reset; tag/data are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_idx] <= 1'b1;
            r_dirty[i_fill_idx] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_rd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_fill_idx]  <= i_fill_tag;
            r_data[i_fill_idx] <= i_fill_data;
        end else if (i_wr_en) begin
            r_data[i_rd_idx][i_wr_off*8 +: 8] <= i_wr_byte;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module  : dcache_controller
// Brief   : Direct-mapped write-back/write-allocate data cache controller.
// Revision: 1.0
// ============================================================================
module dcache_controller
    import cache_defs::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic                 WRITE,
    input  logic [ADDR_W-1:0]    ADDRESS,
    input  logic [7:0]           WRITEDATA,
    output logic [7:0]           READDATA,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic                 MEM_WRITE,
    output logic [MADDR_W-1:0]   MEM_ADDRESS,
    output logic [BLK_W-1:0]     MEM_WRITEDATA,
    input  logic [BLK_W-1:0]     MEM_READDATA,
    input  logic                 MEM_BUSYWAIT
);

    state_t               r_state;
    logic [MADDR_W-1:0]   r_blk_addr;
    logic [BLK_W-1:0]     r_fill_data;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [OFF_W-1:0]     w_off;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_line_tag;
    logic [BLK_W-1:0]     w_line_data;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_wr_hit;
    logic                 w_fill_en;

    assign w_idx     = ADDRESS[OFF_W +: IDX_W];
    assign w_tag     = ADDRESS[ADDR_W-1 -: TAG_W];
    assign w_off     = ADDRESS[OFF_W-1:0];
    assign w_hit     = w_valid && (w_line_tag == w_tag);
    assign w_miss    = (READ || WRITE) && !w_hit;
    assign w_wr_hit  = (r_state == IDLE) && WRITE && w_hit;
    assign w_fill_en = (r_state == ALLOCATE);

    // Outputs forced low while reset is held so a mid-miss abort is seen at once.
    assign BUSYWAIT  = RESET && ((r_state != IDLE) || w_miss);
    assign READDATA  = RESET ? sel_byte(w_line_data, w_off) : 8'd0;

    cache_line_array u_lines (
        .clk         (CLK),
        .rst_n       (RESET),
        .i_rd_idx    (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_line_tag),
        .o_data      (w_line_data),
        .i_wr_en     (w_wr_hit),
        .i_wr_off    (w_off),
        .i_wr_byte   (WRITEDATA),
        .i_fill_en   (w_fill_en),
        .i_fill_idx  (r_blk_addr[IDX_W-1:0]),
        .i_fill_tag  (r_blk_addr[MADDR_W-1 -: TAG_W]),
        .i_fill_data (r_fill_data)
    );

    // The missing block address is latched so the fill lands correctly even if
    // the CPU drops its request part-way through the miss.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            r_blk_addr    <= '0;
            r_fill_data   <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_blk_addr <= ADDRESS[ADDR_W-1:OFF_W];
                        if (w_valid && w_dirty) begin
                            r_state       <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {w_line_tag, w_idx};
                            MEM_WRITEDATA <= w_line_data;
                        end else begin
                            r_state     <= FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= ADDRESS[ADDR_W-1:OFF_W];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state     <= FETCH;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= r_blk_addr;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state     <= ALLOCATE;
                        MEM_READ    <= 1'b0;
                        r_fill_data <= MEM_READDATA;
                    end
                end
                ALLOCATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU data port and Data_Memory.
- The CPU side keeps the existing 8-bit READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake.
- The memory side moves whole 32-bit blocks using Data_Memory's block-level busywait handshake.
- Hits complete without stalling. Misses sequence write-back and fetch through an FSM.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width IDX_W = log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width OFF_W = 2.
- ADDR_W, 8, CPU byte-address width; tag width TAG_W = ADDR_W - IDX_W - OFF_W = 3.

Ports:
- CLK  in  1  system clock; all state updates on the posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request, held until BUSYWAIT is low.
- WRITE  in  1  CPU store request, held until BUSYWAIT is low.
- ADDRESS  in  8  CPU byte address {tag[2:0], index[2:0], offset[1:0]}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  stall to the CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  write-back block, byte 0 in bits [7:0].
- MEM_READDATA  in  32  fetched block, byte 0 in bits [7:0].
- MEM_BUSYWAIT  in  1  memory busy; low means the transfer is done this cycle.

Behaviour:
- Storage per line: valid, dirty, tag[2:0], data[31:0].
- hit = valid[idx] & (tag[idx] == ADDRESS[7:5]).
- Reset (RESET = 0, asynchronous):
  - All valid and dirty bits cleared; FSM to IDLE.
  - BUSYWAIT, MEM_READ and MEM_WRITE are 0; MEM_ADDRESS and MEM_WRITEDATA are 0; READDATA is 0.
  - Assertion mid-miss aborts the transfer immediately, and memory requests drop in the same instant. Tag/data arrays need not be cleared.
- FSM states: IDLE, WRITEBACK, FETCH, ALLOCATE.
- IDLE:
  - BUSYWAIT = (READ | WRITE) & ~hit, combinational.
  - Read hit: READDATA = the selected byte of data[idx], combinational; BUSYWAIT is 0 that cycle and the CPU samples on the next posedge.
  - Write hit: at the posedge, the WRITEDATA byte is written into data[idx] at the offset and dirty[idx] set to 1. BUSYWAIT is 0 that cycle.
  - Miss with ~dirty[idx] -> FETCH. Miss with valid & dirty -> WRITEBACK.
- WRITEBACK:
  - MEM_WRITE = 1, MEM_ADDRESS = {tag[idx], idx}, MEM_WRITEDATA = data[idx]; BUSYWAIT = 1.
  - Hold until MEM_BUSYWAIT is sampled low at a posedge, then -> FETCH.
- FETCH:
  - MEM_READ = 1, MEM_ADDRESS = ADDRESS[7:2]; BUSYWAIT = 1.
  - Hold until MEM_BUSYWAIT is sampled low, then -> ALLOCATE.
- ALLOCATE (one cycle):
  - data[idx] = MEM_READDATA, tag[idx] = ADDRESS[7:5], valid = 1, dirty = 0.
  - BUSYWAIT = 1, MEM requests 0; then -> IDLE, where the access resolves as a hit.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: Tmem + 2 stall cycles.
  - Dirty miss: 2·Tmem + 2 stall cycles.
  - Tmem = number of cycles MEM_BUSYWAIT is high plus 1.
- MEM_READ and MEM_WRITE are never asserted together, and are never asserted in IDLE or ALLOCATE.
- READ and WRITE both high: treated as WRITE.
- READ/WRITE dropped mid-miss: the current WRITEBACK/FETCH/ALLOCATE still completes; IDLE then idles.
- Only ALLOCATE clears a dirty bit; write-back never does.
- READDATA outside a read hit holds the selected byte of the indexed line; its value is don't-care for the CPU.

Decomposition:
- Shared package/header (cache_defs): NUM_BLOCKS, BLOCK_BYTES, TAG_W, IDX_W, OFF_W, and the FSM state encodings (IDLE=2'd0, WRITEBACK=2'd1, FETCH=2'd2, ALLOCATE=2'd3).
- One sub-module, cache_line_array: valid/dirty/tag/data storage with async clear of valid/dirty, byte-write port and block-fill port.
- The controller FSM stays in dcache_controller.

Test Plan:
- Reset then READ addr 0x00, memory block 0 = 0x44332211 -> FETCH with MEM_ADDRESS 0x00, then ALLOCATE; READDATA = 0x11 with BUSYWAIT low. A following READ of 0x03 returns 0x44 with 0 stall cycles.
- WRITE 0xAB to 0x01 after the fill (hit) -> no stall, dirty[0] = 1. READ 0x01 -> 0xAB.
- With line 0 dirty (tag 0), READ 0x20 (tag 1, index 0) -> WRITEBACK with MEM_ADDRESS 0x00 and MEM_WRITEDATA 0x4433AB11, then FETCH with MEM_ADDRESS 0x08. The stall equals 2·Tmem + 2.
- Write miss on clean line 0x14 (index 5) -> FETCH, ALLOCATE, then the byte write. Line 5 ends valid=1, dirty=1 with only the offset-0 byte changed.
- Pull RESET low during FETCH with MEM_BUSYWAIT high -> MEM_READ and BUSYWAIT go 0 immediately. After release, READ to the same address re-misses because valid was cleared.
- READ and WRITE both high on a hit -> the store is performed and BUSYWAIT is low. MEM_READ and MEM_WRITE are never high together across a randomized 500-access run against a reference model.
